group_scan_ctrl: RTL
====================

GROUP_SCAN_CTRL -- requirements
Module: group_scan_ctrl

Interface
REQ-001 The block SHALL have parameter SETTLE_CYCLES, default 1: number of cycles (1..15) a select code is held before the hit line is sampled.
REQ-002 The block SHALL have parameter NGROUPS, default 4: number of select groups scanned; each group owns two adjacent select bits.
REQ-003 The block SHALL have port clk, input, 1: the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst, input, 1: reset, asynchronous and active-high.
REQ-005 The block SHALL have port start, input, 1: request a scan; accepted only in IDLE.
REQ-006 The block SHALL have port group_mask, input, NGROUPS: groups to include in the scan; captured when start is accepted.
REQ-007 The block SHALL have port hit, input, 1: combined activity line returned by the downstream group detector.
REQ-008 The block SHALL have port sel, output, 2*NGROUPS: select word driven to the detector.
REQ-009 The block SHALL have port busy, output, 1: high from accepted start until done.
REQ-010 The block SHALL have port done, output, 1: one-cycle pulse when a scan completes.
REQ-011 The block SHALL have port active, output, NGROUPS: per-group hit result of the last completed scan.
REQ-012 The block SHALL have port any_active, output, 1: OR of active.

Function
REQ-013 The FSM SHALL have states IDLE, DRIVE, SAMPLE, DONE.
REQ-014 In IDLE, sel SHALL be all zero; start=1 SHALL capture group_mask, clear the working result, and move to DRIVE with group index 0.
REQ-015 In DRIVE, if the current group is masked out, the index SHALL advance without driving sel; otherwise sel bits {2g+1,2g} SHALL be 2'b11, all other bits 0.
REQ-016 A driven group SHALL be held for SETTLE_CYCLES cycles, then enter SAMPLE.
REQ-017 In SAMPLE, hit SHALL be registered into working bit g; sel SHALL remain driven during SAMPLE.
REQ-018 After SAMPLE for the last group (index NGROUPS-1), or after skipping it, the FSM SHALL enter DONE.
REQ-019 DONE SHALL last exactly one cycle: done=1, active and any_active updated from the working result, sel=0, then return to IDLE.
REQ-020 An all-zero captured mask SHALL still pass through DONE, producing active=0.
REQ-021 start asserted while busy SHALL be ignored, and SHALL NOT be queued.
REQ-022 active and any_active SHALL hold their values between scans and change only in the DONE cycle.
REQ-023 Total latency for k unmasked groups SHALL be NGROUPS + k*(SETTLE_CYCLES+1) + 1 cycles from start to done, inclusive of skip cycles.

Reset
REQ-024 rst SHALL force IDLE, sel=0, busy=0, done=0, active=0, any_active=0, index=0, working result=0, including when asserted mid-scan.
REQ-025 After rst deasserts, the first start SHALL be accepted on the first rising edge.

Configuration
REQ-026 With macro GROUP_SCAN_EARLY_EXIT_EN defined, a SAMPLE with hit=1 SHALL go directly to DONE, skipping the remaining groups.
REQ-027 Without GROUP_SCAN_EARLY_EXIT_EN, all masked-in groups SHALL always be scanned.

Structure
REQ-028 The FSM state enum, the group-to-select-bit mapping function, and the SETTLE_CYCLES bounds SHALL live in package group_scan_pkg.
REQ-029 The settle counter SHALL be a sub-module group_scan_settle_cnt (load, tick, expired).
REQ-030 The block SHALL be implementable in 120-400 lines of RTL, with no other sub-modules.

Verification
REQ-031 Reset: rst pulse mid-DRIVE with sel=8'h0C -> next cycle sel=0, busy=0, active=0.
REQ-032 Full scan: mask=4'hF, hit=1 only while sel=8'h30, SETTLE_CYCLES=1 -> done after 4+8+1=13 cycles, active=4'b0100, any_active=1.
REQ-033 Masked scan: mask=4'b1010, hit tied 1 -> sel never 8'h03 or 8'h30, active=4'b1010.
REQ-034 Empty mask: mask=0 -> done after 5 cycles, active=0, any_active=0, sel stays 0.
REQ-035 Busy: start re-pulsed during the scan -> exactly one done pulse, and the result reflects the first mask.
REQ-036 With GROUP_SCAN_EARLY_EXIT_EN: mask=4'hF, hit=1 on group 1 -> done follows group 1 SAMPLE, active=4'b0010, sel never 8'h30.

Source files
------------

// File: rtl/group_scan_pkg.sv
// Shared types and helpers for the group scan controller: FSM states,
// settle-count bounds and the group-to-select-bit mapping.
package group_scan_pkg;

  localparam int unsigned SETTLE_MIN = 1;
  localparam int unsigned SETTLE_MAX = 15;
  localparam int unsigned SETTLE_W   = 4;

  typedef enum logic [1:0] {
    IDLE,
    DRIVE,
    SAMPLE,
    DONE
  } state_e;

  // Each group owns the two adjacent select bits starting at this index.
  function automatic int unsigned group_sel_lsb(input int unsigned g);
    return 2 * g;
  endfunction

  function automatic int unsigned settle_clamp(input int unsigned cycles);
    if (cycles < SETTLE_MIN) return SETTLE_MIN;
    if (cycles > SETTLE_MAX) return SETTLE_MAX;
    return cycles;
  endfunction

endpackage

// File: rtl/group_scan_settle_cnt.sv
// Settle-time down-counter: load restarts at LOAD_VAL, tick counts down,
// expired is high once the count has reached zero.
module group_scan_settle_cnt
  import group_scan_pkg::*;
#(
  parameter int unsigned LOAD_VAL = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic tick,
  output logic expired
);

  logic [SETTLE_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = SETTLE_W'(LOAD_VAL);
    end else if (tick && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired = (cnt_q == '0);

endmodule

// File: rtl/group_scan_ctrl.sv
// Group scan controller: walks masked-in select groups, samples the hit line
// per group and publishes the result. GROUP_SCAN_EARLY_EXIT_EN stops on first hit.
module group_scan_ctrl
  import group_scan_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES = 1,
  parameter int unsigned NGROUPS       = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [NGROUPS-1:0]     group_mask,
  input  logic                   hit,
  output logic [2*NGROUPS-1:0]   sel,
  output logic                   busy,
  output logic                   done,
  output logic [NGROUPS-1:0]     active,
  output logic                   any_active
);

  localparam int unsigned      IDX_W     = (NGROUPS > 1) ? $clog2(NGROUPS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NGROUPS - 1);
  localparam int unsigned      SETTLE_LD = settle_clamp(SETTLE_CYCLES);

  state_e               state_q, state_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic [NGROUPS-1:0]   mask_q, mask_d;
  logic [NGROUPS-1:0]   work_q, work_d;
  logic [NGROUPS-1:0]   active_q, active_d;
  logic                 cnt_load, cnt_tick, cnt_expired;
  logic                 last_grp, grp_in, drive_sel;

  group_scan_settle_cnt #(
    .LOAD_VAL(SETTLE_LD)
  ) u_settle (
    .clk    (clk),
    .rst    (rst),
    .load   (cnt_load),
    .tick   (cnt_tick),
    .expired(cnt_expired)
  );

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    mask_d    = mask_q;
    work_d    = work_q;
    active_d  = active_q;
    cnt_load  = 1'b0;
    cnt_tick  = 1'b0;
    drive_sel = 1'b0;
    last_grp  = (idx_q == LAST_IDX);
    grp_in    = mask_q[idx_q];

    case (state_q)
      IDLE: begin
        if (start) begin
          mask_d   = group_mask;
          work_d   = '0;
          idx_d    = '0;
          cnt_load = 1'b1;
          state_d  = DRIVE;
        end
      end
      DRIVE: begin
        if (!grp_in) begin
          if (last_grp) begin
            state_d = DONE;
          end else begin
            idx_d    = idx_q + IDX_W'(1);
            cnt_load = 1'b1;
          end
        end else begin
          drive_sel = 1'b1;
          if (cnt_expired) begin
            state_d = SAMPLE;
          end else begin
            cnt_tick = 1'b1;
          end
        end
      end
      SAMPLE: begin
        drive_sel     = 1'b1;
        work_d[idx_q] = hit;
`ifdef GROUP_SCAN_EARLY_EXIT_EN
        if (last_grp || hit) begin
`else
        if (last_grp) begin
`endif
          state_d = DONE;
        end else begin
          idx_d    = idx_q + IDX_W'(1);
          cnt_load = 1'b1;
          state_d  = DRIVE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
    endcase

    // Publish on the edge into DONE so the new result is visible with the done pulse,
    // including the bit sampled in that same final SAMPLE cycle.
    if ((state_d == DONE) && (state_q != DONE)) begin
      active_d = work_d;
    end
  end

  always_comb begin
    sel = '0;
    if (drive_sel) begin
      sel[group_sel_lsb(32'(idx_q)) +: 2] = 2'b11;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      idx_q    <= '0;
      mask_q   <= '0;
      work_q   <= '0;
      active_q <= '0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      mask_q   <= mask_d;
      work_q   <= work_d;
      active_q <= active_d;
    end
  end

  assign busy       = (state_q != IDLE);
  assign done       = (state_q == DONE);
  assign active     = active_q;
  assign any_active = |active_q;

endmodule
